// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU.
// Contents: datapath widths, PC increment, instruction field positions, the fetch-stage
// state encoding and a word-alignment helper.
package cpu_pkg;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned PC_WIDTH   = 32;
  localparam logic [PC_WIDTH-1:0] PC_INC = 32'd4;

  // Instruction field positions
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS1_MSB    = 25;
  localparam int unsigned RS1_LSB    = 22;
  localparam int unsigned RD_MSB     = 21;
  localparam int unsigned RD_LSB     = 18;
  localparam int unsigned IMM_MSB    = 17;
  localparam int unsigned IMM_LSB    = 2;
  localparam int unsigned MODE_MSB   = 1;
  localparam int unsigned MODE_LSB   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } fetch_state_e;

  // Clears the byte-offset bits of an address.
  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
    return addr & ~PC_WIDTH'(3);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Holds the fetch PC, runs one request/response transaction to instruction memory per
// fetch_start, and presents the fetched word with a one-cycle IRWrite strobe.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_start                start a fetch (ignored while busy)
//   pc_load, pc_target         redirect; applied now when idle, otherwise at completion
//   imem_req/addr/ready        request channel to instruction memory
//   imem_rvalid/rdata          response channel from instruction memory
//   inst_word, pc, pc_next     last fetched word, its address, and address + 4
//   IRWrite, fetch_done        one-cycle completion strobes
//   busy                       transaction in progress
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_start,
  input  logic                  pc_load,
  input  logic [PC_WIDTH-1:0]   pc_target,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] inst_word,
  output logic                  IRWrite,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [PC_WIDTH-1:0]   pc_next,
  output logic                  busy,
  output logic                  fetch_done
);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [PC_WIDTH-3:0]   pend_addr_q, pend_addr_d;
  logic [PC_WIDTH-1:0]   target_aligned;

  assign target_aligned = word_align(pc_target);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;

    unique case (state_q)
      StIdle: begin
        // Redirect lands first so a simultaneous fetch uses the new target.
        if (pc_load) fetch_pc_d = target_aligned;
        if (fetch_start) state_d = StReq;
      end
      StReq: begin
        if (pc_load) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = target_aligned[PC_WIDTH-1:2];
        end
        if (imem_ready) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid) begin
          inst_d       = imem_rdata;
          pc_d         = fetch_pc_q;
          pend_valid_d = 1'b0;
          state_d      = StDone;
          // A redirect arriving with the response beats any older pending one.
          if (pc_load)           fetch_pc_d = target_aligned;
          else if (pend_valid_q) fetch_pc_d = {pend_addr_q, 2'b00};
          else                   fetch_pc_d = fetch_pc_q + PC_INC;
        end else if (pc_load) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = target_aligned[PC_WIDTH-1:2];
        end
      end
      StDone: begin
        if (pc_load) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = target_aligned[PC_WIDTH-1:2];
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  // Strobes decode the state register only, so they carry no input-to-output path.
  assign imem_req   = (state_q == StReq);
  assign IRWrite    = (state_q == StDone);
  assign fetch_done = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign imem_addr  = fetch_pc_q;
  assign inst_word  = inst_q;
  assign pc         = pc_q;
  assign pc_next    = pc_q + PC_INC;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written reset sequence,
// then randomized transactions checked against a transaction-level model.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_target = '0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic        imem_req, IRWrite, busy, fetch_done;
  logic [31:0] imem_addr, inst_word, pc, pc_next;
  logic        w_req, w_irw, w_busy, w_done;
  logic [31:0] w_addr, w_inst, w_pc, w_pc_next;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_target(pc_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_word(inst_word), .IRWrite(IRWrite), .pc(pc), .pc_next(pc_next),
    .busy(busy), .fetch_done(fetch_done)
  );

  // Second instance sees identical stimulus but starts at the top of the address space.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_target(pc_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_word(w_inst), .IRWrite(w_irw), .pc(w_pc), .pc_next(w_pc_next),
    .busy(w_busy), .fetch_done(w_done)
  );

  int n_checks = 0;
  int n_fail = 0;
  int irw_seen = 0;
  int irw_expect = 0;

  // Transaction-level model: next fetch address and pending redirect.
  logic [31:0] m_next = 32'h0;
  logic        m_pend_v = 1'b0;
  logic [31:0] m_pend = 32'h0;

  always @(negedge clk) if (IRWrite) irw_seen++;

  typedef struct {
    int          rdy;
    int          rv;
    logic [31:0] data;
    int          mode;      // 0 none, 1 load with start, 2 load in WAIT, 3 load at completion
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    bit          wrap;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic busy_load(input bit rnd);
    if (rnd && $urandom_range(0, 3) == 0) begin
      pc_load   = 1'b1;
      pc_target = $urandom;
      m_pend_v  = 1'b1;
      m_pend    = pc_target & ~32'd3;
    end else begin
      pc_load = 1'b0;
    end
  endtask

  task automatic fetch_txn(input int rdy_dly, input int rv_dly, input logic [31:0] data,
                           input int mode, input logic [31:0] tgt,
                           input logic [31:0] exp_tbl, input bit use_model, input bit rnd,
                           input bit chk_wrap);
    logic [31:0] exp_addr;
    bit          done_load;
    chk1("idle_busy", busy, 1'b0);
    fetch_start = 1'b1;
    if (mode == 1) begin
      pc_load   = 1'b1;
      pc_target = tgt;
      m_next    = tgt & ~32'd3;
    end
    exp_addr = use_model ? m_next : exp_tbl;
    step();
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    for (int i = 0; i <= rdy_dly; i++) begin
      chk1("req_valid", imem_req, 1'b1);
      chk("req_addr", imem_addr, exp_addr);
      chk1("req_busy", busy, 1'b1);
      if (chk_wrap) chk("wrap_addr", w_addr, exp_addr - 32'd4);
      imem_ready  = (i == rdy_dly);
      fetch_start = rnd ? 1'($urandom_range(0, 1)) : (i == 0);
      imem_rvalid = rnd && !imem_ready && ($urandom_range(0, 1) == 1);
      imem_rdata  = $urandom;
      busy_load(rnd);
      step();
    end
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    for (int i = 0; i <= rv_dly; i++) begin
      chk1("wait_req", imem_req, 1'b0);
      chk1("wait_irw", IRWrite, 1'b0);
      imem_rvalid = (i == rv_dly);
      imem_rdata  = imem_rvalid ? data : $urandom;
      fetch_start = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i == rv_dly) begin
        done_load = (mode == 3) || (rnd && $urandom_range(0, 3) == 0);
        pc_load   = done_load;
        pc_target = (mode == 3) ? tgt : $urandom;
        if (done_load)     m_next = pc_target & ~32'd3;
        else if (m_pend_v) m_next = m_pend;
        else               m_next = exp_addr + 32'd4;
        m_pend_v = 1'b0;
      end else if (mode == 2 && i == 0) begin
        pc_load   = 1'b1;
        pc_target = tgt;
        m_pend_v  = 1'b1;
        m_pend    = tgt & ~32'd3;
      end else begin
        busy_load(rnd);
      end
      step();
    end
    imem_rvalid = 1'b0;
    pc_load     = 1'b0;
    chk1("done_irw", IRWrite, 1'b1);
    chk1("done_fd", fetch_done, 1'b1);
    chk1("done_busy", busy, 1'b1);
    chk1("done_req", imem_req, 1'b0);
    chk("done_inst", inst_word, data);
    chk("done_pc", pc, exp_addr);
    chk("done_pc_next", pc_next, exp_addr + 32'd4);
    if (chk_wrap) begin
      chk("wrap_pc", w_pc, exp_addr - 32'd4);
      chk("wrap_pc_next", w_pc_next, exp_addr);
      chk("wrap_inst", w_inst, data);
    end
    irw_expect++;
    fetch_start = rnd ? 1'($urandom_range(0, 1)) : 1'b1;  // ignored in the DONE cycle
    step();
    fetch_start = 1'b0;
    chk1("idle_irw", IRWrite, 1'b0);
    chk1("idle_fd", fetch_done, 1'b0);
    chk1("idle_req", imem_req, 1'b0);
    chk("idle_inst", inst_word, data);
    chk("idle_pc", pc, exp_addr);
    if (rnd) begin
      for (int k = 0; k < $urandom_range(0, 2); k++) begin
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = $urandom;
        step();
      end
      imem_rvalid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    m_next   = 32'h0;
    m_pend_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 32'h1234_5678, 0, 32'h0,        32'h0000_0000, 1'b1};
    vecs[1] = '{2, 3, 32'hA000_0001, 0, 32'h0,        32'h0000_0004, 1'b1};
    vecs[2] = '{2, 3, 32'hA000_0002, 0, 32'h0,        32'h0000_0008, 1'b0};
    vecs[3] = '{2, 3, 32'hA000_0003, 0, 32'h0,        32'h0000_000C, 1'b0};
    vecs[4] = '{1, 1, 32'hB000_0004, 2, 32'h0000_0103, 32'h0000_0010, 1'b0};
    vecs[5] = '{0, 0, 32'hB000_0005, 0, 32'h0,        32'h0000_0100, 1'b0};
    vecs[6] = '{0, 0, 32'hB000_0006, 1, 32'h0000_0040, 32'h0000_0040, 1'b0};
    vecs[7] = '{1, 2, 32'hB000_0007, 3, 32'h0000_02F7, 32'h0000_0044, 1'b0};
    vecs[8] = '{0, 0, 32'hB000_0008, 0, 32'h0,        32'h0000_02F4, 1'b0};

    // Reset values while held in reset
    step();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_irw", IRWrite, 1'b0);
    chk1("rst_fd", fetch_done, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst_word, 32'h0);
    chk("rst_pc_next", pc_next, 32'h4);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    chk("rst_wrap_pc_next", w_pc_next, 32'h0);
    do_reset();

    foreach (vecs[i])
      fetch_txn(vecs[i].rdy, vecs[i].rv, vecs[i].data, vecs[i].mode, vecs[i].tgt,
                vecs[i].exp_addr, 1'b0, 1'b0, vecs[i].wrap);

    // Reset in WAIT with a redirect pending, then a late response
    do_reset();
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    imem_ready  = 1'b1;
    step();
    imem_ready  = 1'b0;
    pc_load     = 1'b1;
    pc_target   = 32'h0000_0200;
    step();
    pc_load = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_req", imem_req, 1'b0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    step();
    rst_n       = 1'b1;
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk1("late_irw", IRWrite, 1'b0);
    chk1("late_busy", busy, 1'b0);
    chk("late_inst", inst_word, 32'h0);
    step();
    chk1("late_irw2", IRWrite, 1'b0);
    m_next   = 32'h0;
    m_pend_v = 1'b0;
    fetch_txn(0, 0, 32'hC000_0001, 0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    fetch_txn(0, 0, 32'hC000_0002, 0, 32'h0, 32'h0000_0004, 1'b0, 1'b0, 1'b0);

    // Randomized transactions against the model
    do_reset();
    for (int n = 0; n < 40; n++)
      fetch_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                $urandom_range(0, 1), $urandom, 32'h0, 1'b1, 1'b1, 1'b0);

    step();
    chk("irw_count", irw_seen, irw_expect);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multicycle CPU. It holds the fetch program counter, issues a request/response transaction to instruction memory on each fetch command from the control unit, and delivers the 32-bit instruction word together with a one-cycle IRWrite strobe to the instruction register. It directly feeds the instruction register and accepts PC redirects (branch/jump targets) from the execute stage.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (word-aligned)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_start  in  1  control-unit pulse: fetch next instruction
- pc_load  in  1  redirect request from execute stage
- pc_target  in  32  redirect address; bits [1:0] ignored (forced 00)
- imem_req  out  1  request valid to instruction memory
- imem_addr  out  32  request address (fetch_pc)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- inst_word  out  32  last fetched instruction, held stable until next completion
- IRWrite  out  1  one-cycle strobe to instruction register
- pc  out  32  address of instruction currently in inst_word
- pc_next  out  32  pc + 4 (combinational, for link/relative use)
- busy  out  1  fetch in progress (state ≠ IDLE)
- fetch_done  out  1  one-cycle completion pulse to control unit, coincident with IRWrite

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: imem_req=0. fetch_start → REQ. pc_load → fetch_pc ← {pc_target[31:2],2'b00}; if both, redirect applies first and the fetch uses the new target.
- REQ: imem_req=1, imem_addr=fetch_pc, held until imem_ready=1 → WAIT.
- WAIT: imem_req=0. On imem_rvalid: inst_word ← imem_rdata, pc ← fetch_pc, fetch_pc ← pending redirect if any else fetch_pc+4 → DONE.
- DONE: IRWrite=1, fetch_done=1 for exactly one cycle → IDLE.
- pc_load while busy: target stored as pending redirect (latest wins); applied at completion instead of +4; cleared on use. pc_load in the completion cycle overrides +4.
- fetch_start while busy: ignored (not queued).
- imem_rvalid in IDLE, REQ or DONE: ignored.
- Address arithmetic modulo 2^32: fetch_pc 32'hFFFF_FFFC + 4 → 32'h0000_0000.
- Reset (asynchronous, any state, including mid-transaction): state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, inst_word=0, pending redirect cleared, IRWrite=0, fetch_done=0, imem_req=0, busy=0. A response arriving after reset release is ignored.

## Timing
- All outputs registered except pc_next and imem_addr (direct from registers).
- fetch_start at cycle 0 → imem_req=1 in cycle 1; imem_ready in cycle 1, imem_rvalid in cycle 2 → IRWrite/fetch_done in cycle 3. Minimum latency 3 cycles; each ready/rvalid stall adds one cycle.
- imem_rvalid is only valid at least one cycle after acceptance; same-cycle ready+rvalid in REQ is not a legal memory response.
- inst_word and pc change only on the cycle entering DONE; they are stable throughout the IRWrite cycle and afterwards, so the level-sensitive instruction register captures a settled value.
- Back-to-back: fetch_start in the DONE cycle is ignored; earliest next start is the cycle after DONE (IDLE).

## Structure
- Shared cpu_pkg: fetch state enum (IDLE, REQ, WAIT, DONE), INST_WIDTH=32, PC_WIDTH=32, PC_INC=4, instruction field positions (opcode [31:26], Rs1 [25:22], Rd [21:18], imm [17:2], mode [1:0]) for shared use.
- Single module; no sub-module. Pending redirect is a valid bit plus 30-bit address register.

## Test plan
- Reset, fetch_start, ready and rvalid immediate, rdata=32'h1234_5678 → imem_addr=0 in cycle 1; IRWrite cycle 3; inst_word=32'h1234_5678, pc=0, pc_next=4.
- Three consecutive fetches, ready delayed 2 cycles, rvalid delayed 3 → addresses 0,4,8; IRWrite exactly once per fetch; fetch_start while busy produces no extra request.
- pc_load pc_target=32'h0000_0103 in WAIT → completing fetch gives pc=previous fetch_pc; next imem_addr=32'h0000_0100.
- pc_load and fetch_start same IDLE cycle, pc_target=32'h40 → imem_addr=32'h40.
- RESET_PC=32'hFFFF_FFFC: two fetches → addresses 32'hFFFF_FFFC then 32'h0000_0000.
- rst_n low while in WAIT, rvalid pulsed after release → outputs at reset values, no IRWrite, next fetch from RESET_PC.
